// File: rtl/line_data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of a
// command/write/read FIFO memory port. Read misses fill a whole line in one burst.
module line_data_cache #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINES      = 64,
    parameter int unsigned LINE_WORDS = 8,
    parameter logic [29:0] BASE_ADDR  = 30'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  boot_done,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [15:0]           cpu_wdata,
    output logic [15:0]           cpu_rdata,
    output logic                  cpu_ready,
    output logic                  err,
    output logic                  mem_cmd_en,
    output logic [2:0]            mem_cmd_instr,
    output logic [5:0]            mem_cmd_bl,
    output logic [29:0]           mem_cmd_byte_addr,
    input  logic                  mem_cmd_empty,
    input  logic                  mem_cmd_full,
    output logic                  mem_wr_en,
    output logic [3:0]            mem_wr_mask,
    output logic [31:0]           mem_wr_data,
    input  logic                  mem_wr_full,
    input  logic                  mem_wr_empty,
    input  logic [6:0]            mem_wr_count,
    input  logic                  mem_wr_underrun,
    input  logic                  mem_wr_error,
    output logic                  mem_rd_en,
    input  logic [31:0]           mem_rd_data,
    input  logic                  mem_rd_full,
    input  logic                  mem_rd_empty,
    input  logic [6:0]            mem_rd_count,
    input  logic                  mem_rd_overflow,
    input  logic                  mem_rd_error
);
    localparam int unsigned OFF   = $clog2(LINE_WORDS);
    localparam int unsigned IDX   = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX - OFF - 2;

    typedef enum logic [2:0] {INIT, IDLE, LOOKUP, RD_CMD, RD_FILL, WR_DATA, WR_CMD, RESP} state_t;

    state_t state, state_nxt;

    logic [31:0]      data_mem [LINES*LINE_WORDS];
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [LINES-1:0] valid;

    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic                  we_q, we_nxt;
    logic [15:0]           wdata_q, wdata_nxt, cap_q, cap_nxt;
    logic                  hit_q, hit_nxt;
    logic [OFF-1:0]        fill_cnt, fill_nxt;
    logic [OFF:0]          iss_cnt, iss_nxt;
    logic [IDX-1:0]        clr_cnt, clr_nxt;
    logic                  clr_done, clr_done_nxt;

    logic        err_nxt, ready_nxt, cmd_en_nxt, wr_en_nxt, rd_en_nxt;
    logic [15:0] rdata_nxt;
    logic [2:0]  cmd_instr_nxt;
    logic [5:0]  cmd_bl_nxt;
    logic [29:0] cmd_addr_nxt;
    logic [3:0]  wr_mask_nxt;
    logic [31:0] wr_data_nxt;

    logic                 data_we, tag_we, valid_set, valid_clr;
    logic [IDX+OFF-1:0]   data_wa;
    logic [31:0]          data_wd;

    // Request address fields
    logic                  half_q;
    logic [OFF-1:0]        word_q;
    logic [IDX-1:0]        idx_q;
    logic [TAG_W-1:0]      tag_q;
    logic [ADDR_WIDTH-1:0] line_base, word_base;
    logic [31:0]           rd_word;
    logic                  lookup_hit, rd_avail;

    assign half_q     = addr_q[1];
    assign word_q     = addr_q[OFF+1:2];
    assign idx_q      = addr_q[IDX+OFF+1:OFF+2];
    assign tag_q      = addr_q[ADDR_WIDTH-1:IDX+OFF+2];
    assign line_base  = {addr_q[ADDR_WIDTH-1:OFF+2], (OFF+2)'(0)};
    assign word_base  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign rd_word    = data_mem[{idx_q, word_q}];
    assign lookup_hit = valid[idx_q] && (tag_mem[idx_q] == tag_q);
    // rd_en is registered, so an in-flight pop must leave a second word behind
    assign rd_avail   = mem_rd_en ? (mem_rd_count >= 7'd2) : !mem_rd_empty;

    logic unused_ok;
    assign unused_ok = ^{mem_cmd_empty, mem_wr_empty, mem_wr_count, mem_rd_full, addr_q[0]};

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr_q;
        we_nxt        = we_q;
        wdata_nxt     = wdata_q;
        hit_nxt       = hit_q;
        cap_nxt       = cap_q;
        fill_nxt      = fill_cnt;
        iss_nxt       = iss_cnt;
        clr_nxt       = clr_cnt;
        clr_done_nxt  = clr_done;
        err_nxt       = err | mem_wr_error | mem_rd_error | mem_wr_underrun | mem_rd_overflow;
        ready_nxt     = 1'b0;
        rdata_nxt     = 16'h0;
        cmd_en_nxt    = 1'b0;
        cmd_instr_nxt = 3'b000;
        cmd_bl_nxt    = 6'd0;
        cmd_addr_nxt  = 30'h0;
        wr_en_nxt     = 1'b0;
        wr_mask_nxt   = 4'h0;
        wr_data_nxt   = 32'h0;
        rd_en_nxt     = 1'b0;
        data_we       = 1'b0;
        data_wa       = {idx_q, fill_cnt};
        data_wd       = mem_rd_data;
        tag_we        = 1'b0;
        valid_set     = 1'b0;
        valid_clr     = 1'b0;

        case (state)
            INIT: begin
                rd_en_nxt = rd_avail;
                valid_clr = !clr_done;
                clr_nxt   = clr_cnt + IDX'(1);
                if (clr_cnt == IDX'(LINES - 1)) clr_done_nxt = 1'b1;
                if (clr_done && mem_rd_empty && !mem_rd_en) state_nxt = IDLE;
            end
            IDLE: begin
                if (cpu_req && boot_done && !cpu_ready) begin
                    addr_nxt  = cpu_addr;
                    we_nxt    = cpu_we;
                    wdata_nxt = cpu_wdata;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_nxt  = lookup_hit;
                fill_nxt = '0;
                iss_nxt  = '0;
                if (we_q) begin
                    state_nxt = WR_DATA;
                end else if (lookup_hit) begin
                    ready_nxt = 1'b1;
                    rdata_nxt = half_q ? rd_word[31:16] : rd_word[15:0];
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RD_CMD;
                end
            end
            RD_CMD: begin
                if (!mem_cmd_full) begin
                    cmd_en_nxt    = 1'b1;
                    cmd_instr_nxt = 3'b001;
                    cmd_bl_nxt    = 6'(LINE_WORDS - 1);
                    cmd_addr_nxt  = BASE_ADDR + 30'(line_base);
                    state_nxt     = RD_FILL;
                end
            end
            RD_FILL: begin
                if (iss_cnt < (OFF+1)'(LINE_WORDS) && rd_avail) begin
                    rd_en_nxt = 1'b1;
                    iss_nxt   = iss_cnt + (OFF+1)'(1);
                end
                if (mem_rd_en) begin
                    data_we  = 1'b1;
                    fill_nxt = fill_cnt + OFF'(1);
                    if (fill_cnt == word_q)
                        cap_nxt = half_q ? mem_rd_data[31:16] : mem_rd_data[15:0];
                    if (fill_cnt == OFF'(LINE_WORDS - 1)) begin
                        tag_we    = 1'b1;
                        valid_set = 1'b1;
                        state_nxt = RESP;
                    end
                end
            end
            WR_DATA: begin
                if (!mem_wr_full) begin
                    wr_en_nxt   = 1'b1;
                    wr_data_nxt = {wdata_q, wdata_q};
                    wr_mask_nxt = half_q ? 4'b0011 : 4'b1100;
                    data_we     = hit_q;
                    data_wa     = {idx_q, word_q};
                    data_wd     = half_q ? {wdata_q, rd_word[15:0]} : {rd_word[31:16], wdata_q};
                    state_nxt   = WR_CMD;
                end
            end
            WR_CMD: begin
                if (!mem_cmd_full) begin
                    cmd_en_nxt    = 1'b1;
                    cmd_instr_nxt = 3'b000;
                    cmd_bl_nxt    = 6'd0;
                    cmd_addr_nxt  = BASE_ADDR + 30'(word_base);
                    state_nxt     = RESP;
                end
            end
            RESP: begin
                ready_nxt = 1'b1;
                rdata_nxt = we_q ? 16'h0 : cap_q;
                state_nxt = IDLE;
            end
            default: state_nxt = INIT;
        endcase
    end

    // State, request context and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= INIT;
            addr_q            <= '0;
            we_q              <= 1'b0;
            wdata_q           <= 16'h0;
            hit_q             <= 1'b0;
            cap_q             <= 16'h0;
            fill_cnt          <= '0;
            iss_cnt           <= '0;
            clr_cnt           <= '0;
            clr_done          <= 1'b0;
            err               <= 1'b0;
            cpu_ready         <= 1'b0;
            cpu_rdata         <= 16'h0;
            mem_cmd_en        <= 1'b0;
            mem_cmd_instr     <= 3'b000;
            mem_cmd_bl        <= 6'd0;
            mem_cmd_byte_addr <= 30'h0;
            mem_wr_en         <= 1'b0;
            mem_wr_mask       <= 4'h0;
            mem_wr_data       <= 32'h0;
            mem_rd_en         <= 1'b0;
        end else begin
            state             <= state_nxt;
            addr_q            <= addr_nxt;
            we_q              <= we_nxt;
            wdata_q           <= wdata_nxt;
            hit_q             <= hit_nxt;
            cap_q             <= cap_nxt;
            fill_cnt          <= fill_nxt;
            iss_cnt           <= iss_nxt;
            clr_cnt           <= clr_nxt;
            clr_done          <= clr_done_nxt;
            err               <= err_nxt;
            cpu_ready         <= ready_nxt;
            cpu_rdata         <= rdata_nxt;
            mem_cmd_en        <= cmd_en_nxt;
            mem_cmd_instr     <= cmd_instr_nxt;
            mem_cmd_bl        <= cmd_bl_nxt;
            mem_cmd_byte_addr <= cmd_addr_nxt;
            mem_wr_en         <= wr_en_nxt;
            mem_wr_mask       <= wr_mask_nxt;
            mem_wr_data       <= wr_data_nxt;
            mem_rd_en         <= rd_en_nxt;
        end
    end

    // Line storage; valid bits are cleared by INIT rather than by reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (data_we) data_mem[data_wa] <= data_wd;
            if (tag_we)  tag_mem[idx_q]    <= tag_q;
            if (valid_clr)      valid[clr_cnt] <= 1'b0;
            else if (valid_set) valid[idx_q]   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_line_data_cache.sv
// Directed bench for line_data_cache: FIFO/memory model, vector table and
// hand-written stall, reset-during-fill, error and address-wrap sequences.
module tb_line_data_cache;
    logic        clk = 1'b0;
    logic        rst_n, boot_done, cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready, err;
    logic        mem_cmd_en, mem_wr_en, mem_rd_en;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic [3:0]  mem_wr_mask;
    logic [31:0] mem_wr_data, mem_rd_data;
    logic        mem_cmd_full, mem_wr_full, rd_hold;
    logic        mem_rd_empty, mem_rd_overflow;
    logic [6:0]  mem_rd_count;

    // Second instance with a wrapping base address
    logic        w_ready, w_err, w_cmd_en, w_wr_en, w_rd_en;
    logic [15:0] w_rdata;
    logic [2:0]  w_instr;
    logic [5:0]  w_bl;
    logic [29:0] w_addr;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;

    always #5 clk = ~clk;

    line_data_cache dut (
        .clk(clk), .rst_n(rst_n), .boot_done(boot_done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .err(err),
        .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr), .mem_cmd_bl(mem_cmd_bl),
        .mem_cmd_byte_addr(mem_cmd_byte_addr), .mem_cmd_empty(1'b1), .mem_cmd_full(mem_cmd_full),
        .mem_wr_en(mem_wr_en), .mem_wr_mask(mem_wr_mask), .mem_wr_data(mem_wr_data),
        .mem_wr_full(mem_wr_full), .mem_wr_empty(1'b1), .mem_wr_count(7'd0),
        .mem_wr_underrun(1'b0), .mem_wr_error(1'b0),
        .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data), .mem_rd_full(1'b0),
        .mem_rd_empty(mem_rd_empty), .mem_rd_count(mem_rd_count),
        .mem_rd_overflow(mem_rd_overflow), .mem_rd_error(1'b0)
    );

    line_data_cache #(.BASE_ADDR(30'h3FFFFFF0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .boot_done(boot_done),
        .cpu_req(1'b1), .cpu_we(1'b0), .cpu_addr(16'h0020), .cpu_wdata(16'h0),
        .cpu_rdata(w_rdata), .cpu_ready(w_ready), .err(w_err),
        .mem_cmd_en(w_cmd_en), .mem_cmd_instr(w_instr), .mem_cmd_bl(w_bl),
        .mem_cmd_byte_addr(w_addr), .mem_cmd_empty(1'b1), .mem_cmd_full(1'b0),
        .mem_wr_en(w_wr_en), .mem_wr_mask(w_mask), .mem_wr_data(w_wdata),
        .mem_wr_full(1'b0), .mem_wr_empty(1'b1), .mem_wr_count(7'd0),
        .mem_wr_underrun(1'b0), .mem_wr_error(1'b0),
        .mem_rd_en(w_rd_en), .mem_rd_data(32'h0), .mem_rd_full(1'b0),
        .mem_rd_empty(1'b1), .mem_rd_count(7'd0),
        .mem_rd_overflow(1'b0), .mem_rd_error(1'b0)
    );

    // Memory + FIFO model
    logic [31:0] mem [1024];
    logic [31:0] rdq [$];
    logic [35:0] wrq [$];
    int          rd_n = 0;
    logic [31:0] rd_front = 32'h0;
    int          cmd_cnt = 0, pop_cnt = 0, wr_cnt = 0, viol = 0;
    logic [2:0]  last_instr;
    logic [5:0]  last_bl;
    logic [29:0] last_caddr;
    logic [31:0] last_wdata;
    logic [3:0]  last_mask;
    logic        prev_ready = 1'b0;
    int          w_cmds = 0;
    logic [29:0] w_last_addr = 30'h0;
    logic [5:0]  w_last_bl = 6'd0;

    assign mem_rd_empty = rd_hold || (rd_n == 0);
    assign mem_rd_count = rd_hold ? 7'd0 : 7'(rd_n);
    assign mem_rd_data  = rd_front;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            if (mem_rd_empty || rdq.size() == 0) viol++;
            else begin void'(rdq.pop_front()); pop_cnt++; end
        end
        if (mem_wr_en) begin
            if (mem_wr_full) viol++;
            wrq.push_back({mem_wr_mask, mem_wr_data});
            wr_cnt++; last_wdata = mem_wr_data; last_mask = mem_wr_mask;
        end
        if (mem_cmd_en) begin
            if (mem_cmd_full) viol++;
            cmd_cnt++; last_instr = mem_cmd_instr; last_bl = mem_cmd_bl; last_caddr = mem_cmd_byte_addr;
            if (mem_cmd_instr == 3'b001) begin
                for (int i = 0; i <= int'(mem_cmd_bl); i++)
                    rdq.push_back(mem[(int'(mem_cmd_byte_addr >> 2) + i) % 1024]);
            end else if (wrq.size() == 0) begin
                viol++;
            end else begin
                logic [35:0] e;
                int wi;
                e = wrq.pop_front();
                wi = int'(mem_cmd_byte_addr >> 2) % 1024;
                for (int b = 0; b < 4; b++)
                    if (!e[32+b]) mem[wi][8*b +: 8] = e[8*b +: 8];
            end
        end
        if (cpu_ready && prev_ready) viol++;
        prev_ready = cpu_ready;
        if (w_cmd_en) begin w_cmds++; w_last_addr = w_addr; w_last_bl = w_bl; end
        rd_n     <= rdq.size();
        rd_front <= (rdq.size() != 0) ? rdq[0] : 32'h0;
    end

    int checks = 0, errors = 0, tmo = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cpu_op(input bit we, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int lat);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        lat = 0; rd = 16'h0;
        while (lat < 1000) begin
            @(negedge clk);
            lat++;
            if (cpu_ready) begin rd = cpu_rdata; break; end
        end
        if (!cpu_ready) begin tmo++; lat = -1; end
        cpu_req = 1'b0;
    endtask

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          cmds;
        int          pops;
        int          lat;
        logic [2:0]  instr;
        logic [29:0] caddr;
        logic [3:0]  mask;
    } vec_t;

    vec_t vt [12];
    logic [15:0] rd;
    int lat, c0, p0, w0, n;
    int s_c1, s_c2, s_p1, s_p2, s_w1, s_w2, lat2;
    logic [15:0] rd2;

    initial begin
        for (int i = 0; i < 1024; i++)
            mem[i] = {16'h5000 + 16'(2*i + 1), 16'h5000 + 16'(2*i)};
        vt[0]  = '{0, 16'h0012, 16'h0,    16'h5009, 0, 0, 2, 3'd0, 30'h0,   4'h0};
        vt[1]  = '{1, 16'h0012, 16'hBEEF, 16'h0,    1, 0, 0, 3'd0, 30'h10,  4'b0011};
        vt[2]  = '{0, 16'h0012, 16'h0,    16'hBEEF, 0, 0, 2, 3'd0, 30'h0,   4'h0};
        vt[3]  = '{0, 16'h0010, 16'h0,    16'h5008, 0, 0, 2, 3'd0, 30'h0,   4'h0};
        vt[4]  = '{1, 16'h0104, 16'h1234, 16'h0,    1, 0, 0, 3'd0, 30'h104, 4'b1100};
        vt[5]  = '{0, 16'h0104, 16'h0,    16'h1234, 1, 8, 0, 3'd1, 30'h100, 4'h0};
        vt[6]  = '{0, 16'h0106, 16'h0,    16'h5083, 0, 0, 2, 3'd0, 30'h0,   4'h0};
        vt[7]  = '{0, 16'h0810, 16'h0,    16'h5408, 1, 8, 0, 3'd1, 30'h800, 4'h0};
        vt[8]  = '{0, 16'h0010, 16'h0,    16'h5008, 1, 8, 0, 3'd1, 30'h0,   4'h0};
        vt[9]  = '{0, 16'h0012, 16'h0,    16'hBEEF, 0, 0, 2, 3'd0, 30'h0,   4'h0};
        vt[10] = '{1, 16'h0816, 16'hA5A5, 16'h0,    1, 0, 0, 3'd0, 30'h814, 4'b0011};
        vt[11] = '{0, 16'h0016, 16'h0,    16'h500B, 0, 0, 2, 3'd0, 30'h0,   4'h0};

        rst_n = 1'b0; boot_done = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = 16'h0; cpu_wdata = 16'h0;
        mem_cmd_full = 1'b0; mem_wr_full = 1'b0; rd_hold = 1'b0; mem_rd_overflow = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, cpu_ready}, 0);
        chk("rst_rdata", {16'h0, cpu_rdata}, 0);
        chk("rst_err",   {31'h0, err}, 0);
        chk("rst_outs",  {29'h0, mem_cmd_en, mem_wr_en, mem_rd_en}, 0);
        chk("rst_caddr", {2'b0, mem_cmd_byte_addr}, 0);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);

        // Request without boot_done is ignored, then served once released
        c0 = cmd_cnt; p0 = pop_cnt; n = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        repeat (10) begin @(negedge clk); if (cpu_ready) n++; end
        chk("t1_noready", n, 0);
        chk("t1_nocmd", cmd_cnt - c0, 0);
        boot_done = 1'b1; n = 0;
        while (!cpu_ready && n < 500) begin @(negedge clk); n++; end
        chk("t1_done", {31'h0, cpu_ready}, 1);
        chk("t1_rdata", {16'h0, cpu_rdata}, 32'h5008);
        cpu_req = 1'b0;
        chk("t1_cmds", cmd_cnt - c0, 1);
        chk("t1_instr", {29'h0, last_instr}, 1);
        chk("t1_bl", {26'h0, last_bl}, 7);
        chk("t1_caddr", {2'b0, last_caddr}, 0);
        chk("t1_pops", pop_cnt - p0, 8);
        chk("wrap_caddr", {2'b0, w_last_addr}, 32'h10);
        chk("wrap_bl", {26'h0, w_last_bl}, 7);

        for (int i = 0; i < 12; i++) begin
            c0 = cmd_cnt; p0 = pop_cnt; w0 = wr_cnt;
            cpu_op(vt[i].we, vt[i].addr, vt[i].wdata, rd, lat);
            if (!vt[i].we) chk($sformatf("v%0d_rdata", i), {16'h0, rd}, {16'h0, vt[i].rdata});
            chk($sformatf("v%0d_cmds", i), cmd_cnt - c0, vt[i].cmds);
            chk($sformatf("v%0d_pops", i), pop_cnt - p0, vt[i].pops);
            if (vt[i].lat != 0) chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            if (vt[i].cmds != 0) begin
                chk($sformatf("v%0d_instr", i), {29'h0, last_instr}, {29'h0, vt[i].instr});
                chk($sformatf("v%0d_caddr", i), {2'b0, last_caddr}, {2'b0, vt[i].caddr});
            end
            if (vt[i].we) begin
                chk($sformatf("v%0d_wrs", i), wr_cnt - w0, 1);
                chk($sformatf("v%0d_wdata", i), last_wdata, {vt[i].wdata, vt[i].wdata});
                chk($sformatf("v%0d_mask", i), {28'h0, last_mask}, {28'h0, vt[i].mask});
            end
        end

        // Stalled miss: full command FIFO, then empty read FIFO
        @(negedge clk);
        mem_cmd_full = 1'b1; mem_wr_full = 1'b1; rd_hold = 1'b1;
        c0 = cmd_cnt; p0 = pop_cnt;
        fork
            cpu_op(1'b0, 16'h0200, 16'h0, rd, lat);
            begin
                repeat (20) @(negedge clk);
                s_c1 = cmd_cnt - c0; s_p1 = pop_cnt - p0;
                mem_cmd_full = 1'b0;
                repeat (20) @(negedge clk);
                s_c2 = cmd_cnt - c0; s_p2 = pop_cnt - p0;
                rd_hold = 1'b0;
            end
        join
        chk("t4_stall_cmd", s_c1, 0);
        chk("t4_stall_pop1", s_p1, 0);
        chk("t4_cmd_after", s_c2, 1);
        chk("t4_stall_pop2", s_p2, 0);
        chk("t4_rdata", {16'h0, rd}, 32'h5100);
        chk("t4_pops", pop_cnt - p0, 8);
        chk("t4_slow", {31'h0, lat > 40}, 1);

        // Stalled store: data must precede its command
        @(negedge clk);
        mem_cmd_full = 1'b1; mem_wr_full = 1'b1;
        c0 = cmd_cnt; w0 = wr_cnt;
        fork
            cpu_op(1'b1, 16'h0202, 16'h7777, rd, lat);
            begin
                repeat (20) @(negedge clk);
                s_w1 = wr_cnt - w0; s_c1 = cmd_cnt - c0;
                mem_cmd_full = 1'b0;
                repeat (10) @(negedge clk);
                s_w2 = wr_cnt - w0; s_c2 = cmd_cnt - c0;
                mem_wr_full = 1'b0;
            end
        join
        chk("t4w_stall_wr", s_w1, 0);
        chk("t4w_stall_cmd", s_c1, 0);
        chk("t4w_wr_held", s_w2, 0);
        chk("t4w_cmd_held", s_c2, 0);
        chk("t4w_wrs", wr_cnt - w0, 1);
        chk("t4w_cmds", cmd_cnt - c0, 1);
        chk("t4w_wdata", last_wdata, 32'h77777777);
        chk("t4w_mask", {28'h0, last_mask}, 4'b0011);
        chk("t4w_caddr", {2'b0, last_caddr}, 32'h200);
        cpu_op(1'b0, 16'h0202, 16'h0, rd2, lat2);
        chk("t4w_reload", {16'h0, rd2}, 32'h7777);
        chk("t4w_relat", lat2, 2);

        // Sticky error
        chk("t6_err0", {31'h0, err}, 0);
        @(negedge clk); mem_rd_overflow = 1'b1;
        @(negedge clk); mem_rd_overflow = 1'b0;
        @(negedge clk);
        chk("t6_err1", {31'h0, err}, 1);
        repeat (10) @(negedge clk);
        chk("t6_sticky", {31'h0, err}, 1);

        // Reset in the middle of a line fill
        c0 = cmd_cnt; p0 = pop_cnt; n = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
        while ((pop_cnt - p0) < 3 && n < 200) begin @(negedge clk); n++; end
        chk("t5_reach3", {31'h0, n < 200}, 1);
        rst_n = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        chk("t5_rst_outs", {29'h0, cpu_ready, mem_cmd_en, mem_rd_en}, 0);
        chk("t5_err_clr", {31'h0, err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("t5_drained", rd_n, 0);
        chk("t5_allpops", pop_cnt - p0, 8);
        c0 = cmd_cnt;
        cpu_op(1'b0, 16'h0300, 16'h0, rd, lat);
        chk("t5_miss", cmd_cnt - c0, 1);
        chk("t5_rdata", {16'h0, rd}, 32'h5180);

        repeat (5) @(negedge clk);
        chk("protocol_viol", viol, 0);
        chk("timeouts", tmo, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
